rom_program_sequencer: RTL and testbench

//  Control unit that fetches and executes the 2-bit instruction program held in
//  the 4-word instruction ROM. Drives the ROM select lines as a program counter,

---
 rtl/rom_program_sequencer.sv | 93 +++++++++
 tb/tb_rom_program_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rom_program_sequencer.sv
// rom_program_sequencer: fetch/execute sequencer for a 4-word ROM holding 2-bit opcodes
module rom_program_sequencer #(
  parameter int ACC_W      = 2,
  parameter int JNO_TARGET = 0,
  parameter int MAX_STEPS  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       rom_data,
  output logic [1:0]       rom_addr,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic             timeout
);
  localparam int SW = $clog2(MAX_STEPS + 1);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t           state, state_n;
  logic [1:0]       pc, pc_n, ir, ir_n;
  logic [ACC_W-1:0] acc_n;
  logic             ovf_n, err_n, to_n;
  logic [SW-1:0]    cnt, cnt_n;
  logic [ACC_W:0]   sum;
  assign sum      = {1'b0, acc} + (ACC_W + 1)'(1);
  assign rom_addr = pc;
  // next-state and datapath update; INC/JNO fall through to FETCH, HLT/illegal stop
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    err_n   = err;
    to_n    = timeout;
    case (state)
      IDLE, HALT: if (start) begin
        state_n = FETCH;
        pc_n    = '0;
        acc_n   = '0;
        ovf_n   = 1'b0;
        cnt_n   = '0;
        err_n   = 1'b0;
        to_n    = 1'b0;
      end
      FETCH: begin
        ir_n    = rom_data;
        state_n = EXEC;
      end
      default: begin
        cnt_n   = cnt + SW'(1);
        state_n = ir[1] ? HALT : FETCH;
        err_n   = (ir == 2'b11) ? 1'b1 : err;
        {ovf_n, acc_n} = (ir == 2'b00) ? sum : {ovf, acc};
        pc_n    = (ir == 2'b00 || (ir == 2'b01 && ovf)) ? pc + 2'd1 :
                  (ir == 2'b01) ? 2'(JNO_TARGET) : pc;
        if (!ir[1] && cnt_n == SW'(MAX_STEPS)) begin
          to_n    = 1'b1;
          state_n = HALT;
        end
      end
    endcase
  end
  // state and output registers; busy/halted are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      err     <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      acc     <= acc_n;
      ovf     <= ovf_n;
      cnt     <= cnt_n;
      err     <= err_n;
      timeout <= to_n;
      busy    <= (state_n == FETCH || state_n == EXEC);
      halted  <= (state_n == HALT);
    end
  end
endmodule

// File: tb/tb_rom_program_sequencer.sv
// tb_rom_program_sequencer: three parameterisations run against a program-level reference model
module tb_rom_program_sequencer;
  localparam int AW [3] = '{2, 2, 1};
  localparam int TG [3] = '{0, 2, 0};
  localparam int MS [3] = '{64, 6, 64};
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] rom [3][4];
  logic [2:0][1:0] ra, ac;
  logic a2;
  logic [2:0] ov, bz, hl, er, tm;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign ac[2] = {1'b0, a2};
  rom_program_sequencer #(.ACC_W(2), .JNO_TARGET(0), .MAX_STEPS(64)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(rom[0][ra[0]]), .rom_addr(ra[0]),
    .acc(ac[0]), .ovf(ov[0]), .busy(bz[0]), .halted(hl[0]), .err(er[0]), .timeout(tm[0]));
  rom_program_sequencer #(.ACC_W(2), .JNO_TARGET(2), .MAX_STEPS(6)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(rom[1][ra[1]]), .rom_addr(ra[1]),
    .acc(ac[1]), .ovf(ov[1]), .busy(bz[1]), .halted(hl[1]), .err(er[1]), .timeout(tm[1]));
  rom_program_sequencer #(.ACC_W(1), .JNO_TARGET(0), .MAX_STEPS(64)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_data(rom[2][ra[2]]), .rom_addr(ra[2]),
    .acc(a2), .ovf(ov[2]), .busy(bz[2]), .halted(hl[2]), .err(er[2]), .timeout(tm[2]));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // executes the program instruction by instruction; returns final architectural state and count
  function automatic void model(input logic [1:0] r [4], input int aw, input int tg, input int ms,
                                output int a, output int o, output int p, output int e,
                                output int t, output int n);
    a = 0; o = 0; p = 0; e = 0; t = 0; n = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] op;
      op = r[p];
      n++;
      if (op == 2'd3) begin e = 1; break; end
      if (op == 2'd2) break;
      if (op == 2'd0) begin
        a = a + 1;
        o = (a >= (1 << aw)) ? 1 : 0;
        a = a % (1 << aw);
        p = (p + 1) % 4;
      end else p = o ? (p + 1) % 4 : tg;
      if (n == ms) begin t = 1; break; end
    end
  endfunction

  task automatic run(input bit mid, input bit trace);
    int ea [3], eo [3], ep [3], ee [3], et [3], en [3], hc [3];
    logic [1:0] r [4];
    bit m;
    m = mid;
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 4; j++) r[j] = rom[d][j];
      model(r, AW[d], TG[d], MS[d], ea[d], eo[d], ep[d], ee[d], et[d], en[d]);
      hc[d] = -1;
      if (en[d] < 3) m = 1'b0;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < 3; d++) if (hl[d] && hc[d] < 0) hc[d] = k;
      if (trace && k % 2 == 0 && k < 12) chk($sformatf("d1_addr_seq_k%0d", k), ra[1], (k / 2) % 4);
      if (hc[0] >= 0 && hc[1] >= 0 && hc[2] >= 0) break;
      start = m && k == 3;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_halt_cycle", d), hc[d], 2 * en[d]);
      chk($sformatf("d%0d_acc", d), ac[d], ea[d]);
      chk($sformatf("d%0d_ovf", d), ov[d], eo[d]);
      chk($sformatf("d%0d_rom_addr", d), ra[d], ep[d]);
      chk($sformatf("d%0d_err", d), er[d], ee[d]);
      chk($sformatf("d%0d_timeout", d), tm[d], et[d]);
      chk($sformatf("d%0d_busy_halted", d), {bz[d], hl[d]}, 2'b01);
    end
  endtask

  initial begin
    rom[0] = '{2'd0, 2'd1, 2'd0, 2'd2};
    rom[1] = '{2'd0, 2'd0, 2'd0, 2'd0};
    rom[2] = '{2'd0, 2'd0, 2'd2, 2'd0};
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_in_reset", d), {ra[d], ac[d], ov[d], bz[d], hl[d], er[d], tm[d]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_idle", d), {ra[d], ac[d], ov[d], bz[d], hl[d], er[d], tm[d]}, 0);
    run(1'b0, 1'b1);
    run(1'b1, 1'b0);
    for (int d = 0; d < 3; d++) rom[d][0] = 2'd3;
    run(1'b0, 1'b0);
    rom[0][0] = 2'd0;
    rom[1][0] = 2'd0;
    rom[2][0] = 2'd0;
    run(1'b0, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_async_reset", d), {ra[d], ac[d], ov[d], bz[d], hl[d], er[d], tm[d]}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int it = 0; it < 25; it++) begin
      for (int d = 0; d < 3; d++)
        for (int j = 0; j < 4; j++) rom[d][j] = 2'($urandom_range(0, 3));
      run(1'($urandom_range(0, 1)), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
